// File: rtl/config_scheduler.sv
// config_scheduler: sequences configuration attempts with per-byte timeout, parity retry and bounded attempts.
module config_scheduler #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       byte_recebido,
    input  logic       pronto_config,
    input  logic       erro_config,
    output logic       receber_config,
    output logic       limpa_config,
    output logic       ocupado,
    output logic       config_ok,
    output logic       config_falha,
    output logic [1:0] tentativa,
    output logic [2:0] bytes_contados
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ULTIMA = 2'(MAX_TENTATIVAS - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        DISPARA = 3'd1,
        AGUARDA = 3'd2,
        LIMPA   = 3'd3,
        REPETE  = 3'd4,
        SUCESSO = 3'd5,
        FALHA   = 3'd6
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    tent_q, tent_d;
    logic [2:0]    bytes_q, bytes_d;
    logic          receber_q, limpa_q, ocupado_q, ok_q, falha_q;

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        tent_d   = tent_q;
        bytes_d  = bytes_q;
        case (estado_q)
            OCIOSO, SUCESSO, FALHA: begin
                if (iniciar) begin
                    estado_d = DISPARA;
                    tent_d   = '0;
                end
            end
            DISPARA: begin
                estado_d = AGUARDA;
                timer_d  = '0;
                bytes_d  = '0;
            end
            AGUARDA: begin
                // completion beats a byte, and a byte beats the timeout on the same cycle
                if (pronto_config) begin
                    estado_d = erro_config ? REPETE : SUCESSO;
                end else if (byte_recebido) begin
                    timer_d = '0;
                    bytes_d = (bytes_q == 3'd5) ? bytes_q : bytes_q + 3'd1;
                end else if (timer_q == TIMER_LAST) begin
                    estado_d = LIMPA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            LIMPA: estado_d = REPETE;
            REPETE: begin
                if (tent_q == ULTIMA) begin
                    estado_d = FALHA;
                end else begin
                    estado_d = DISPARA;
                    tent_d   = tent_q + 2'd1;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // outputs are registered copies of the next-state decode, so they track the state exactly
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            timer_q   <= '0;
            tent_q    <= '0;
            bytes_q   <= '0;
            receber_q <= 1'b0;
            limpa_q   <= 1'b0;
            ocupado_q <= 1'b0;
            ok_q      <= 1'b0;
            falha_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            timer_q   <= timer_d;
            tent_q    <= tent_d;
            bytes_q   <= bytes_d;
            receber_q <= (estado_d == DISPARA);
            limpa_q   <= (estado_d == LIMPA);
            ocupado_q <= (estado_d inside {DISPARA, AGUARDA, LIMPA, REPETE});
            ok_q      <= (estado_d == SUCESSO);
            falha_q   <= (estado_d == FALHA);
        end
    end

    assign receber_config = receber_q;
    assign limpa_config   = limpa_q;
    assign ocupado        = ocupado_q;
    assign config_ok      = ok_q;
    assign config_falha   = falha_q;
    assign tentativa      = tent_q;
    assign bytes_contados = bytes_q;
endmodule

// File: doc/config_scheduler.md
CONFIG_SCHEDULER -- requirements
Module: config_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000; max clock cycles allowed between consecutive received config bytes.
REQ-002 SHALL have parameter MAX_TENTATIVAS, default 3; total config attempts (first try included) before declaring failure, range 1..3.
REQ-003 SHALL have port clock  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset (0 = reset), single clock domain.
REQ-005 SHALL have port iniciar  input  1  request to start a configuration sequence, level-sampled.
REQ-006 SHALL have port byte_recebido  input  1  one-cycle pulse from serial receiver per received config byte.
REQ-007 SHALL have port pronto_config  input  1  config manager finished (success or parity error).
REQ-008 SHALL have port erro_config  input  1  config manager parity error, valid with pronto_config.
REQ-009 SHALL have port receber_config  output  1  one-cycle start pulse to config manager.
REQ-010 SHALL have port limpa_config  output  1  one-cycle pulse forcing config manager back to its initial state.
REQ-011 SHALL have port ocupado  output  1  sequence in progress.
REQ-012 SHALL have port config_ok  output  1  last sequence succeeded, held.
REQ-013 SHALL have port config_falha  output  1  last sequence exhausted all attempts, held.
REQ-014 SHALL have port tentativa  output  2  zero-based index of current/last attempt.
REQ-015 SHALL have port bytes_contados  output  3  bytes received in current attempt, saturating at 5.

Function
REQ-016 SHALL implement FSM states OCIOSO, DISPARA, AGUARDA, LIMPA, REPETE, SUCESSO, FALHA.
REQ-017 OCIOSO: iniciar=1 -> DISPARA with tentativa cleared to 0; else stay.
REQ-018 DISPARA: receber_config=1 for exactly this cycle; timer and bytes_contados cleared; unconditional -> AGUARDA.
REQ-019 AGUARDA: timer increments each cycle; byte_recebido=1 clears timer and increments bytes_contados (saturate at 5).
REQ-020 AGUARDA: pronto_config=1 and erro_config=0 -> SUCESSO; pronto_config=1 and erro_config=1 -> REPETE.
REQ-021 AGUARDA: timer reaching TIMEOUT_CYCLES-1 with no byte_recebido and no pronto_config that cycle -> LIMPA.
REQ-022 Priority in AGUARDA: pronto_config > byte_recebido > timeout; a byte arriving on the timeout cycle cancels the timeout.
REQ-023 LIMPA: limpa_config=1 for exactly this cycle; unconditional -> REPETE.
REQ-024 REPETE: tentativa == MAX_TENTATIVAS-1 -> FALHA; else tentativa increments, -> DISPARA.
REQ-025 SUCESSO: config_ok=1 held; iniciar=1 -> DISPARA with tentativa cleared, config_ok dropped.
REQ-026 FALHA: config_falha=1 held; iniciar=1 -> DISPARA with tentativa cleared, config_falha dropped.
REQ-027 ocupado=1 exactly in DISPARA, AGUARDA, LIMPA, REPETE; iniciar ignored while ocupado.
REQ-028 receber_config and limpa_config SHALL never be asserted in the same cycle; all outputs registered or decoded from state only (Moore).
REQ-029 Timer width SHALL be ceil(log2(TIMEOUT_CYCLES)) bits, no wrap-around before timeout detection.
REQ-030 Undefined state encodings SHALL return to OCIOSO on next clock.

Reset
REQ-031 reset=0 SHALL immediately force OCIOSO, timer=0, tentativa=0, bytes_contados=0, all 1-bit outputs 0, independent of clock.
REQ-032 reset asserted mid-sequence SHALL abort without issuing limpa_config; first edge after reset release evaluates OCIOSO.

Verification
REQ-033 Nominal: iniciar 1 cycle, 5 byte_recebido pulses 10 cycles apart, then pronto_config=1 erro_config=0 -> receber_config pulse 1 cycle after iniciar, bytes_contados=5, config_ok=1, tentativa=0, ocupado=0.
REQ-034 Parity retry: TIMEOUT_CYCLES=20; first attempt ends pronto=1 erro=1, second ends pronto=1 erro=0 -> two receber_config pulses, tentativa=1, config_ok=1.
REQ-035 Timeout exhaustion: TIMEOUT_CYCLES=20, MAX_TENTATIVAS=3, no bytes -> 3 limpa_config pulses each 20 cycles after AGUARDA entry, config_falha=1, tentativa=2.
REQ-036 Boundary: byte_recebido on exact timeout cycle -> no limpa_config, timer restarts; 7 bytes received -> bytes_contados=5.
REQ-037 Async reset: reset=0 in AGUARDA between clock edges -> outputs 0 before next edge; after release, iniciar restarts with tentativa=0.
REQ-038 Restart: from FALHA, iniciar=1 -> config_falha drops, receber_config pulses, nominal completion gives config_ok=1.
